// File: rtl/spi_arbiter_if.sv
// Bundle between two SPI requesters, the arbiter and the shared byte engine.
// The master view belongs to the arbiter; the slave view belongs to the environment.
interface spi_arbiter_if;
  logic       req0;
  logic       req1;
  logic       start0;
  logic       start1;
  logic [7:0] din0;
  logic [7:0] din1;
  logic       grant0;
  logic       grant1;
  logic       done0;
  logic       done1;
  logic [7:0] dout0;
  logic [7:0] dout1;
  logic       spi_start;
  logic [7:0] spi_data_in;
  logic       spi_done;
  logic [7:0] spi_data_out;
  logic       cs_n;
  logic       wdog_err;

  modport master (
    input  req0, req1, start0, start1, din0, din1,
    input  spi_done, spi_data_out,
    output grant0, grant1, done0, done1, dout0, dout1,
    output spi_start, spi_data_in, cs_n, wdog_err
  );

  modport slave (
    output req0, req1, start0, start1, din0, din1,
    output spi_done, spi_data_out,
    input  grant0, grant1, done0, done1, dout0, dout1,
    input  spi_start, spi_data_in, cs_n, wdog_err
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine between two requesters,
// with chip-select gap on release and an idle-owner watchdog.
module spi_arbiter #(
  parameter int GAP_CYCLES  = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          reset,
  spi_arbiter_if.master bus
);

  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(WDOG_CYCLES - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    XFER,
    RELEASE
  } state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           grant0_q, grant0_d;
  logic           grant1_q, grant1_d;
  logic           cs_n_q, cs_n_d;
  logic           spi_start_q, spi_start_d;
  logic [7:0]     spi_din_q, spi_din_d;
  logic           done0_q, done0_d;
  logic           done1_q, done1_d;
  logic [7:0]     dout0_q, dout0_d;
  logic [7:0]     dout1_q, dout1_d;
  logic           wdog_q, wdog_d;

  logic       own_req;
  logic       own_start;
  logic [7:0] own_din;
  logic       any_req;
  logic       pick;
  logic       go_grab;
  logic       go_rel;

  assign own_req   = owner_q ? bus.req1 : bus.req0;
  assign own_start = owner_q ? bus.start1 : bus.start0;
  assign own_din   = owner_q ? bus.din1 : bus.din0;
  assign any_req   = bus.req0 | bus.req1;
  assign pick      = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    grant0_d    = grant0_q;
    grant1_d    = grant1_q;
    cs_n_d      = cs_n_q;
    spi_start_d = 1'b0;
    spi_din_d   = spi_din_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    dout0_d     = dout0_q;
    dout1_d     = dout1_q;
    wdog_d      = 1'b0;
    go_grab     = 1'b0;
    go_rel      = 1'b0;

    unique case (state_q)
      IDLE: go_grab = any_req;
      OWN: begin
        wd_d = wd_q + 1'b1;
        if (!own_req) begin
          go_rel = 1'b1;
        end else if (own_start) begin
          spi_start_d = 1'b1;
          spi_din_d   = own_din;
          wd_d        = '0;
          state_d     = XFER;
        end else if (wd_q == WD_MAX) begin
          wdog_d = 1'b1;
          go_rel = 1'b1;
        end
      end
      XFER: begin
        wd_d = wd_q + 1'b1;
        if (bus.spi_done) begin
          done0_d = ~owner_q;
          done1_d = owner_q;
          if (owner_q) dout1_d = bus.spi_data_out;
          else         dout0_d = bus.spi_data_out;
          wd_d = '0;
          if (own_req) state_d = OWN;
          else         go_rel  = 1'b1;
        end else if (wd_q == WD_MAX) begin
          wdog_d = 1'b1;
          go_rel = 1'b1;
        end
      end
      RELEASE: begin
        // last gap cycle arbitrates directly so cs_n stays high exactly GAP_CYCLES
        if (gap_q == GAP_MAX) begin
          if (any_req) go_grab = 1'b1;
          else         state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_rel) begin
      state_d  = RELEASE;
      grant0_d = 1'b0;
      grant1_d = 1'b0;
      cs_n_d   = 1'b1;
      last_d   = owner_q;
      gap_d    = '0;
      wd_d     = '0;
    end

    if (go_grab) begin
      state_d  = OWN;
      owner_d  = pick;
      grant0_d = ~pick;
      grant1_d = pick;
      cs_n_d   = 1'b0;
      wd_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      wd_q        <= '0;
      gap_q       <= '0;
      grant0_q    <= 1'b0;
      grant1_q    <= 1'b0;
      cs_n_q      <= 1'b1;
      spi_start_q <= 1'b0;
      spi_din_q   <= 8'hFF;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      dout0_q     <= 8'h00;
      dout1_q     <= 8'h00;
      wdog_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
      grant0_q    <= grant0_d;
      grant1_q    <= grant1_d;
      cs_n_q      <= cs_n_d;
      spi_start_q <= spi_start_d;
      spi_din_q   <= spi_din_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
      wdog_q      <= wdog_d;
    end
  end

  assign bus.grant0      = grant0_q;
  assign bus.grant1      = grant1_q;
  assign bus.cs_n        = cs_n_q;
  assign bus.spi_start   = spi_start_q;
  assign bus.spi_data_in = spi_din_q;
  assign bus.done0       = done0_q;
  assign bus.done1       = done1_q;
  assign bus.dout0       = dout0_q;
  assign bus.dout1       = dout1_q;
  assign bus.wdog_err    = wdog_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: grant latency, round-robin, engine
// isolation, gap timing, watchdog and mid-transfer reset.
module tb_spi_arbiter;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  spi_arbiter_if bus ();

  spi_arbiter #(
    .GAP_CYCLES (2),
    .WDOG_CYCLES(1024)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_g0"}, bus.grant0, 1'b0);
    chk({tag, "_g1"}, bus.grant1, 1'b0);
    chk({tag, "_csn"}, bus.cs_n, 1'b1);
    chk({tag, "_ss"}, bus.spi_start, 1'b0);
    chk({tag, "_sdi"}, bus.spi_data_in, 8'hFF);
    chk({tag, "_d0"}, bus.done0, 1'b0);
    chk({tag, "_d1"}, bus.done1, 1'b0);
    chk({tag, "_o0"}, bus.dout0, 8'h00);
    chk({tag, "_o1"}, bus.dout1, 8'h00);
    chk({tag, "_wd"}, bus.wdog_err, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.req0 = 0; bus.req1 = 0;
    bus.start0 = 0; bus.start1 = 0;
    bus.din0 = 0; bus.din1 = 0;
    bus.spi_done = 0; bus.spi_data_out = 0;
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b1;
    tick();
    chk("idle_csn", bus.cs_n, 1'b1);

    // first grant, one-cycle latency
    bus.req0 = 1;
    tick();
    chk("grant0", bus.grant0, 1'b1);
    chk("grant0_g1", bus.grant1, 1'b0);
    chk("grant0_csn", bus.cs_n, 1'b0);
    bus.start0 = 1; bus.din0 = 8'h40;
    tick();
    bus.start0 = 0;
    chk("start_ss", bus.spi_start, 1'b1);
    chk("start_sdi", bus.spi_data_in, 8'h40);

    // starts during XFER ignored
    bus.start0 = 1; bus.start1 = 1; bus.din0 = 8'h11; bus.din1 = 8'h22;
    tick();
    bus.start0 = 0; bus.start1 = 0;
    chk("start_pulse", bus.spi_start, 1'b0);
    tick();
    chk("xfer_nostart", bus.spi_start, 1'b0);
    chk("xfer_sdi", bus.spi_data_in, 8'h40);
    bus.spi_done = 1; bus.spi_data_out = 8'hFE;
    tick();
    bus.spi_done = 0;
    chk("done0", bus.done0, 1'b1);
    chk("dout0", bus.dout0, 8'hFE);
    chk("done1_quiet", bus.done1, 1'b0);
    tick();
    chk("done0_pulse", bus.done0, 1'b0);

    // non-owner start and stray spi_done in OWN
    bus.start1 = 1; bus.din1 = 8'h55;
    tick();
    bus.start1 = 0;
    chk("nonowner_ss", bus.spi_start, 1'b0);
    bus.spi_done = 1; bus.spi_data_out = 8'h33;
    tick();
    bus.spi_done = 0;
    chk("stray_done", bus.done0, 1'b0);
    chk("stray_dout", bus.dout0, 8'hFE);

    // req drop during XFER still delivers the byte
    bus.start0 = 1; bus.din0 = 8'hA5;
    tick();
    bus.start0 = 0;
    chk("s2_ss", bus.spi_start, 1'b1);
    chk("s2_sdi", bus.spi_data_in, 8'hA5);
    bus.req0 = 0;
    tick();
    chk("drop_hold_g0", bus.grant0, 1'b1);
    chk("drop_hold_csn", bus.cs_n, 1'b0);
    bus.spi_done = 1; bus.spi_data_out = 8'h3C;
    tick();
    bus.spi_done = 0;
    chk("drop_done0", bus.done0, 1'b1);
    chk("drop_dout0", bus.dout0, 8'h3C);
    chk("drop_rel_g0", bus.grant0, 1'b0);
    chk("drop_rel_csn", bus.cs_n, 1'b1);
    tick(); tick(); tick();
    chk("idle_after", bus.cs_n, 1'b1);

    // both requesting from reset: 0 first, then 1 after a 2-cycle gap
    reset = 0;
    tick();
    reset = 1;
    bus.req0 = 1; bus.req1 = 1;
    tick();
    chk("rr_g0", bus.grant0, 1'b1);
    chk("rr_g1_low", bus.grant1, 1'b0);
    bus.req0 = 0;
    tick();
    chk("gap1_csn", bus.cs_n, 1'b1);
    chk("gap1_g0", bus.grant0, 1'b0);
    tick();
    chk("gap2_csn", bus.cs_n, 1'b1);
    chk("gap2_g1", bus.grant1, 1'b0);
    tick();
    chk("rr_g1", bus.grant1, 1'b1);
    chk("rr_g1_csn", bus.cs_n, 1'b0);

    // owner 1 releases while 0 waits; 1 re-requests at once but 0 wins
    bus.req0 = 1; bus.req1 = 0;
    tick();
    bus.req1 = 1;
    chk("rr2_rel", bus.grant1, 1'b0);
    tick(); tick();
    chk("rr2_g0", bus.grant0, 1'b1);
    chk("rr2_g1", bus.grant1, 1'b0);
    bus.req0 = 0;
    tick(); tick(); tick();
    chk("rr3_g1", bus.grant1, 1'b1);
    chk("rr3_g0", bus.grant0, 1'b0);

    // watchdog on idle owner 1
    repeat (1023) tick();
    chk("wd_pre_err", bus.wdog_err, 1'b0);
    chk("wd_pre_g1", bus.grant1, 1'b1);
    tick();
    chk("wd_err", bus.wdog_err, 1'b1);
    chk("wd_g1", bus.grant1, 1'b0);
    chk("wd_csn", bus.cs_n, 1'b1);
    tick();
    chk("wd_pulse", bus.wdog_err, 1'b0);
    bus.req1 = 0;
    tick(); tick(); tick();

    // reset during XFER
    bus.req0 = 1;
    tick();
    bus.start0 = 1; bus.din0 = 8'h99;
    tick();
    bus.start0 = 0;
    chk("rx_ss", bus.spi_start, 1'b1);
    tick();
    reset = 0;
    bus.req0 = 0;
    #1;
    chk_reset_vals("rx");
    tick();
    reset = 1;
    tick(); tick();
    bus.spi_done = 1; bus.spi_data_out = 8'h77;
    tick();
    bus.spi_done = 0;
    chk("late_done0", bus.done0, 1'b0);
    chk("late_done1", bus.done1, 1'b0);
    chk("late_dout0", bus.dout0, 8'h00);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
